// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB sequencer:
//   - mode_e         : operating mode encodings (OFF / CYCLE / BLINK / HOLD)
//   - RGB_*_BIT      : bit positions of the red/green/blue drives in a 3-bit word
//   - COLOUR_*       : named colour constants
//   - IDX_FIRST/LAST : range of the CYCLE colour index (0 is never used)
//   - next_colour_idx: 1 -> 2 -> ... -> 7 -> 1 successor
//   - gate_rgb       : blank an RGB word when the PWM stage is in its off time
// -----------------------------------------------------------------------------
package rgb_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_CYCLE = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_HOLD  = 2'b11
   } mode_e;

   localparam int unsigned RGB_R_BIT = 32'd2;
   localparam int unsigned RGB_G_BIT = 32'd1;
   localparam int unsigned RGB_B_BIT = 32'd0;

   localparam logic [2:0] COLOUR_OFF = 3'b000;
   localparam logic [2:0] RED        = 3'b100;
   localparam logic [2:0] GREEN      = 3'b010;
   localparam logic [2:0] BLUE       = 3'b001;
   localparam logic [2:0] WHITE      = 3'b111;

   localparam logic [2:0] IDX_FIRST  = 3'd1;
   localparam logic [2:0] IDX_LAST   = 3'd7;

   // Successor in the 1..7 colour walk; an illegal 0 recovers to the start.
   function automatic logic [2:0] next_colour_idx(input logic [2:0] idx);
      logic [2:0] nxt;
      if ((idx == IDX_LAST) || (idx == 3'd0)) begin
         nxt = IDX_FIRST;
      end else begin
         nxt = idx + 3'd1;
      end
      return nxt;
   endfunction

   // Pass the colour through while the PWM stage is on, otherwise dark.
   function automatic logic [2:0] gate_rgb(input logic [2:0] rgb, input logic on);
      logic [2:0] res;
      if (on) begin
         res = rgb;
      end else begin
         res = COLOUR_OFF;
      end
      return res;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Prescaler producing a registered one-cycle pulse every DIV clock cycles.
// The counter runs 0..DIV-1 while enabled and is cleared while disabled, so a
// re-enable always starts a fresh, full period.
//
// Parameters:
//   DIV    : division ratio, must be >= 2
// Ports:
//   clk    : input  clock, rising edge
//   rst    : input  asynchronous active-high reset
//   enable : input  1 = count, 0 = clear counter and suppress the tick
//   tick   : output registered pulse, high for one cycle as the counter wraps
// -----------------------------------------------------------------------------
module tick_divider
   import rgb_pkg::*;
#(
   parameter int unsigned DIV = 32'd8
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int unsigned      CNT_W   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 32'd1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tick_q;
   logic             tick_d;

   // Next counter value and tick flag.
   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (!enable) begin
         cnt_d  = '0;
         tick_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + CNT_W'(1);
         tick_d = 1'b0;
      end
   end

   // Counter and tick registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/rgb_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_sequencer
// Drives a 3-bit RGB LED with four modes: OFF, colour CYCLE (1..7), BLINK of a
// selected colour, and HOLD of a selected colour. A PWM stage scales the
// brightness; a tick_divider sets the step rate for CYCLE and BLINK.
//
// Parameters:
//   CLK_HZ     : input clock frequency in Hz
//   STEP_HZ    : step rate in Hz (CLK_HZ/STEP_HZ must be >= 2)
//   PWM_BITS   : width of brightness and of the PWM counter
// Ports:
//   clk        : input  clock, rising edge
//   rst        : input  asynchronous active-high reset
//   enable     : input  1 = run, 0 = blank display and freeze state
//   mode       : input  00 OFF, 01 CYCLE, 10 BLINK, 11 HOLD
//   colour     : input  colour for BLINK/HOLD (bit2 R, bit1 G, bit0 B)
//   brightness : input  PWM duty, 0 = dark, all-ones = always on
//   display    : output registered RGB drive
//   colour_idx : output current CYCLE colour index, 1..7
//   step_tick  : output one-cycle pulse at each step boundary
// -----------------------------------------------------------------------------
module rgb_sequencer
   import rgb_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 32'd100_000_000,
   parameter int unsigned STEP_HZ  = 32'd1,
   parameter int unsigned PWM_BITS = 32'd4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [2:0]          colour,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [2:0]          display,
   output logic [2:0]          colour_idx,
   output logic                step_tick
);

   localparam int unsigned         DIV         = CLK_HZ / STEP_HZ;
   localparam logic [PWM_BITS-1:0] BRIGHT_FULL = '1;

   logic                step_tick_s;
   logic                pwm_on_s;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] pwm_cnt_d;
   mode_e               mode_s;
   mode_e               mode_q;
   logic [2:0]          colour_idx_q;
   logic                blink_phase_q;
   logic [2:0]          display_q;
   logic [2:0]          display_d;

   tick_divider #(
      .DIV(DIV)
   ) u_step_div (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .tick  (step_tick_s)
   );

   assign mode_s = mode_e'(mode);

   // Free-running PWM counter, held at zero while disabled.
   always_comb begin
      pwm_cnt_d = '0;
      if (enable) begin
         pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      end else begin
         pwm_cnt_d = '0;
      end
   end

   // PWM counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   // Full-scale brightness is forced on; otherwise the compare gives
   // brightness on-cycles per 2^PWM_BITS period. Brightness is used live.
   assign pwm_on_s = (brightness == BRIGHT_FULL) || (pwm_cnt_q < brightness);

   // Next display word from the registered mode/index/phase and live inputs.
   always_comb begin
      display_d = COLOUR_OFF;
      if (!enable) begin
         display_d = COLOUR_OFF;
      end else begin
         case (mode_q)
            MODE_OFF:   display_d = COLOUR_OFF;
            MODE_CYCLE: display_d = gate_rgb(colour_idx_q, pwm_on_s);
            MODE_BLINK: display_d = gate_rgb(blink_phase_q ? colour : COLOUR_OFF, pwm_on_s);
            MODE_HOLD:  display_d = gate_rgb(colour, pwm_on_s);
            default:    display_d = COLOUR_OFF;
         endcase
      end
   end

   // Mode FSM with colour index, blink phase and registered display.
   // A mode change takes priority over a coincident step tick, so entering
   // CYCLE or BLINK always starts from index 1 / the on phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q        <= MODE_OFF;
         colour_idx_q  <= IDX_FIRST;
         blink_phase_q <= 1'b1;
         display_q     <= COLOUR_OFF;
      end else begin
         display_q <= display_d;
         if (enable) begin
            if (mode_s != mode_q) begin
               mode_q <= mode_s;
               case (mode_s)
                  MODE_CYCLE: colour_idx_q  <= IDX_FIRST;
                  MODE_BLINK: blink_phase_q <= 1'b1;
                  default:    ;
               endcase
            end else if (step_tick_s) begin
               case (mode_q)
                  MODE_CYCLE: colour_idx_q  <= next_colour_idx(colour_idx_q);
                  MODE_BLINK: blink_phase_q <= ~blink_phase_q;
                  default:    ;
               endcase
            end
         end
      end
   end

   assign display    = display_q;
   assign colour_idx = colour_idx_q;
   assign step_tick  = step_tick_s;

endmodule

// File: tb/tb_rgb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_sequencer
// Self-checking bench for rgb_sequencer with CLK_HZ=8, STEP_HZ=1, PWM_BITS=2.
// A cycle-level behavioural model tracks the expected outputs on every clock;
// a vector table covers PWM duty in HOLD/OFF, and hand-written sequences cover
// reset, tick/mode-change priority, blink restart and enable gating.
// -----------------------------------------------------------------------------
module tb_rgb_sequencer;

   localparam int CLK_HZ     = 8;
   localparam int STEP_HZ    = 1;
   localparam int PWM_BITS   = 2;
   localparam int DIV        = CLK_HZ / STEP_HZ;
   localparam int PWM_PERIOD = 1 << PWM_BITS;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic [1:0]          mode;
   logic [2:0]          colour;
   logic [PWM_BITS-1:0] brightness;
   logic [2:0]          display;
   logic [2:0]          colour_idx;
   logic                step_tick;

   int n_pass  = 0;
   int n_total = 0;

   // Model state (plain integers)
   int         m_presc;
   int         m_pwm;
   int         m_idx;
   int         m_mode;
   bit         m_tick;
   bit         m_phase;
   logic [2:0] m_disp;

   typedef struct {
      logic [1:0] mode;
      logic [2:0] colour;
      logic [1:0] bright;
      int         exp_on;   // cycles out of 8 with a lit display
   } vec_t;

   vec_t vecs[8];

   rgb_sequencer #(
      .CLK_HZ  (CLK_HZ),
      .STEP_HZ (STEP_HZ),
      .PWM_BITS(PWM_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .mode      (mode),
      .colour    (colour),
      .brightness(brightness),
      .display   (display),
      .colour_idx(colour_idx),
      .step_tick (step_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_presc = 0; m_pwm = 0; m_tick = 0;
      m_idx = 1; m_phase = 1; m_mode = 0; m_disp = 3'b000;
   endtask

   // One rising edge of the behavioural model, computed from the old values.
   task automatic model_edge();
      bit         on;
      logic [2:0] shown;
      int         br;
      if (rst) begin
         model_reset();
      end else if (!enable) begin
         m_disp = 3'b000; m_tick = 0; m_presc = 0; m_pwm = 0;
      end else begin
         br = int'(brightness);
         on = (br == PWM_PERIOD - 1) || (m_pwm < br);
         case (m_mode)
            0:       shown = 3'b000;
            1:       shown = 3'(m_idx);
            2:       shown = m_phase ? colour : 3'b000;
            default: shown = colour;
         endcase
         m_disp = on ? shown : 3'b000;
         if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            if (m_mode == 1) m_idx = 1;
            if (m_mode == 2) m_phase = 1;
         end else if (m_tick) begin
            if (m_mode == 1) m_idx = (m_idx % 7) + 1;
            if (m_mode == 2) m_phase = !m_phase;
         end
         m_tick  = (m_presc == DIV - 1);
         m_presc = (m_presc + 1) % DIV;
         m_pwm   = (m_pwm + 1) % PWM_PERIOD;
      end
   endtask

   // Advance one clock and compare every output against the model.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("display", display, m_disp);
      chk("colour_idx", colour_idx, m_idx);
      chk("step_tick", step_tick, m_tick);
   endtask

   // Step until step_tick is seen high; n returns cycles taken.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while ((step_tick !== 1'b1) && (n < 3 * DIV));
      if (step_tick !== 1'b1) chk("tick_timeout", 0, 1);
   endtask

   // Step until colour_idx equals want, bounded.
   task automatic wait_idx(input int want);
      int n;
      n = 0;
      while ((colour_idx !== 3'(want)) && (n < 10 * DIV)) begin
         step();
         n++;
      end
      chk("wait_idx_reached", colour_idx, want);
   endtask

   initial begin
      int         n;
      int         lit;
      int         stray;
      logic [2:0] first;
      int         exp_seq[8];

      vecs[0] = '{2'b11, 3'b100, 2'd1, 2};
      vecs[1] = '{2'b11, 3'b100, 2'd2, 4};
      vecs[2] = '{2'b11, 3'b100, 2'd0, 0};
      vecs[3] = '{2'b11, 3'b100, 2'd3, 8};
      vecs[4] = '{2'b11, 3'b000, 2'd3, 0};
      vecs[5] = '{2'b00, 3'b111, 2'd3, 0};
      vecs[6] = '{2'b11, 3'b011, 2'd2, 4};
      vecs[7] = '{2'b11, 3'b111, 2'd1, 2};
      exp_seq = '{2, 3, 4, 5, 6, 7, 1, 2};

      rst = 1'b1; enable = 1'b0; mode = 2'b00; colour = 3'b000; brightness = 2'd0;
      model_reset();
      repeat (2) step();
      rst = 1'b0;

      // Get away from the reset state, then reset asynchronously mid-cycle
      enable = 1'b1; mode = 2'b01; brightness = 2'd3;
      repeat (20) step();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_display", display, 3'b000);
      chk("async_rst_idx", colour_idx, 1);
      chk("async_rst_tick", step_tick, 0);
      model_reset();
      repeat (3) step();
      rst = 1'b0;

      // CYCLE: index walk, tick period and display following index
      enable = 1'b1; mode = 2'b01; brightness = 2'd3;
      for (int k = 0; k < 8; k++) begin
         wait_tick(n);
         if (k > 0) chk("tick_period", n + 2, DIV);
         step();
         chk("cycle_seq", colour_idx, exp_seq[k]);
         step();
         chk("cycle_display", display, exp_seq[k]);
      end

      // PWM duty table in HOLD / OFF
      for (int v = 0; v < 8; v++) begin
         mode = vecs[v].mode; colour = vecs[v].colour; brightness = vecs[v].bright;
         repeat (2) step();
         lit = 0; stray = 0;
         for (int c = 0; c < 8; c++) begin
            step();
            if (display !== 3'b000) lit++;
            if ((display !== 3'b000) && (display !== vecs[v].colour)) stray++;
         end
         chk("pwm_on_count", lit, vecs[v].exp_on);
         chk("pwm_stray_bits", stray, 0);
      end

      // BLINK entered from HOLD restarts lit; then 8 on / 8 off
      mode = 2'b11; colour = 3'b010; brightness = 2'd3;
      repeat (3) step();
      mode = 2'b10;
      repeat (2) step();
      chk("blink_restart_on", display, 3'b010);
      wait_tick(n);
      step(); step();
      first = display;
      for (int c = 0; c < 7; c++) begin
         step();
         chk("blink_hold_phase", display, first);
      end
      step();
      chk("blink_toggle", display, (first == 3'b010) ? 3'b000 : 3'b010);

      // Mode change to CYCLE coinciding with a step tick
      mode = 2'b01;
      step();
      wait_idx(5);
      mode = 2'b11;
      step();
      wait_tick(n);
      chk("pre_change_idx", colour_idx, 5);
      mode = 2'b01;
      step();
      chk("change_beats_tick", colour_idx, 1);
      wait_tick(n);
      step();
      chk("after_change_step", colour_idx, 2);

      // enable = 0 mid-CYCLE freezes, re-enable restarts a full step
      wait_idx(4);
      enable = 1'b0;
      step();
      chk("disable_display", display, 3'b000);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("disable_tick", step_tick, 0);
         chk("disable_idx", colour_idx, 4);
      end
      enable = 1'b1;
      for (int c = 0; c < DIV - 1; c++) begin
         step();
         chk("reenable_no_tick", step_tick, 0);
      end
      step();
      chk("reenable_tick", step_tick, 1);
      step();
      chk("reenable_idx", colour_idx, 5);

      // Randomised run against the model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) colour = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) brightness = 2'($urandom_range(0, 3));
         if (enable) begin
            if ($urandom_range(0, 59) == 0) enable = 1'b0;
         end else begin
            if ($urandom_range(0, 3) == 0) enable = 1'b1;
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
